// File: rtl/lct_l1a_window_if.sv
// lct_l1a_window_if: the L1A-window block's control, pulse and counter bundle.
// master = driver of the LCT/L1A stimulus and consumer of the status
// slave  = the window logic itself
interface lct_l1a_window_if #(
    parameter int CNT_W = 8
);
    logic             ce;
    logic             lct_dly;
    logic             l1a;
    logic [3:0]       win;
    logic             cnt_clr;
    logic             busy;
    logic             l1a_match;
    logic             no_l1a;
    logic             l1a_orphan;
    logic             lct_ovlp;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output ce, lct_dly, l1a, win, cnt_clr,
        input  busy, l1a_match, no_l1a, l1a_orphan, lct_ovlp, match_cnt, miss_cnt
    );

    modport slave (
        input  ce, lct_dly, l1a, win, cnt_clr,
        output busy, l1a_match, no_l1a, l1a_orphan, lct_ovlp, match_cnt, miss_cnt
    );
endinterface

// File: rtl/lct_l1a_window.sv
// lct_l1a_window: opens a (WIN+1)-cycle L1A acceptance window on each delayed
// LCT, classifies it as matched / missed, and flags stray L1As and LCTs that
// land inside an already-open window. All outputs are registered.
//
// Optional feature: define MATCH_CNT_EN to build the saturating match/miss
// counters; without it MATCH_CNT/MISS_CNT read 0 and CNT_CLR is ignored.
//
// The down-counter holds the number of window edges still to come after the
// current one, so a window opened at edge k closes exactly at edge k+WIN.
// With WIN=0 the whole window is the opening edge: the verdict (match or
// miss) is produced there and the FSM never leaves IDLE, so BUSY stays low.
module lct_l1a_window #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    lct_l1a_window_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;

    logic match_s;
    logic miss_s;
    logic orphan_s;
    logic ovlp_s;

    logic busy_r;
    logic match_r;
    logic miss_r;
    logic orphan_r;
    logic ovlp_r;

    // Next-state, down-counter and pulse decode; everything holds while CE=0.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        match_s  = 1'b0;
        miss_s   = 1'b0;
        orphan_s = 1'b0;
        ovlp_s   = 1'b0;
        if (bus.ce) begin
            case (state_r)
                IDLE: begin
                    if (bus.lct_dly) begin
                        if (bus.win == 4'd0) begin
                            // Single-edge window: decide right here.
                            cnt_s   = 4'd0;
                            state_s = IDLE;
                            if (bus.l1a) begin
                                match_s = 1'b1;
                            end else begin
                                miss_s = 1'b1;
                            end
                        end else begin
                            cnt_s = bus.win - 4'd1;
                            if (bus.l1a) begin
                                match_s = 1'b1;
                                state_s = DONE;
                            end else begin
                                state_s = OPEN;
                            end
                        end
                    end else if (bus.l1a) begin
                        orphan_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                OPEN: begin
                    ovlp_s  = bus.lct_dly;
                    match_s = bus.l1a;
                    if (cnt_r == 4'd0) begin
                        // Last edge of the window.
                        state_s = IDLE;
                        miss_s  = ~bus.l1a;
                    end else begin
                        cnt_s   = cnt_r - 4'd1;
                        state_s = bus.l1a ? DONE : OPEN;
                    end
                end
                DONE: begin
                    // Already matched: run the window out at fixed length.
                    ovlp_s   = bus.lct_dly;
                    orphan_s = bus.l1a;
                    if (cnt_r == 4'd0) begin
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
    end

    // FSM state and window down-counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered status and one-cycle pulse outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r   <= 1'b0;
            match_r  <= 1'b0;
            miss_r   <= 1'b0;
            orphan_r <= 1'b0;
            ovlp_r   <= 1'b0;
        end else begin
            busy_r   <= (state_s != IDLE);
            match_r  <= match_s;
            miss_r   <= miss_s;
            orphan_r <= orphan_s;
            ovlp_r   <= ovlp_s;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.l1a_match  = match_r;
    assign bus.no_l1a     = miss_r;
    assign bus.l1a_orphan = orphan_r;
    assign bus.lct_ovlp   = ovlp_r;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    // Saturating increment: all-ones is sticky.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Match/miss counters; a clear beats an increment on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            match_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else if (bus.ce && bus.cnt_clr) begin
            match_cnt_r <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (match_s) begin
                match_cnt_r <= sat_inc(match_cnt_r);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
            if (miss_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign bus.match_cnt = match_cnt_r;
    assign bus.miss_cnt  = miss_cnt_r;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = {CNT_W{1'b0}};
    assign bus.miss_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lct_l1a_window.sv
// tb_lct_l1a_window: directed scenarios plus randomized traffic, every cycle
// compared against a window-level reference model (edges-left bookkeeping).
module tb_lct_l1a_window;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    lct_l1a_window_if #(.CNT_W(CNT_W)) bus ();

    lct_l1a_window #(.CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a window either is open (with a number of edges still
    // to come after the current one) or is not.
    bit m_open;
    int m_left;
    bit m_matched;
    bit e_busy, e_match, e_miss, e_orphan, e_ovlp;
    int e_match_cnt, e_miss_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_open      = 1'b0;
        m_left      = 0;
        m_matched   = 1'b0;
        e_busy      = 1'b0;
        e_match     = 1'b0;
        e_miss      = 1'b0;
        e_orphan    = 1'b0;
        e_ovlp      = 1'b0;
        e_match_cnt = 0;
        e_miss_cnt  = 0;
    endtask

    task automatic model_edge();
        e_match  = 1'b0;
        e_miss   = 1'b0;
        e_orphan = 1'b0;
        e_ovlp   = 1'b0;
        if (bus.ce) begin
            if (m_open) begin
                if (bus.lct_dly) e_ovlp = 1'b1;
                if (bus.l1a) begin
                    if (m_matched) e_orphan = 1'b1;
                    else begin
                        e_match   = 1'b1;
                        m_matched = 1'b1;
                    end
                end
                m_left--;
                if (m_left == 0) begin
                    m_open = 1'b0;
                    if (!m_matched) e_miss = 1'b1;
                end
            end else if (bus.lct_dly) begin
                m_matched = bus.l1a;
                e_match   = bus.l1a;
                m_left    = int'(bus.win) + 1;
                m_left--;
                if (m_left == 0) begin
                    if (!bus.l1a) e_miss = 1'b1;
                end else begin
                    m_open = 1'b1;
                end
            end else if (bus.l1a) begin
                e_orphan = 1'b1;
            end
            e_busy = m_open;
`ifdef MATCH_CNT_EN
            if (bus.cnt_clr) begin
                e_match_cnt = 0;
                e_miss_cnt  = 0;
            end else begin
                if (e_match && e_match_cnt < CNT_MAX) e_match_cnt++;
                if (e_miss && e_miss_cnt < CNT_MAX) e_miss_cnt++;
            end
`endif
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".busy"},      int'(bus.busy),       int'(e_busy));
        check({tag, ".match"},     int'(bus.l1a_match),  int'(e_match));
        check({tag, ".no_l1a"},    int'(bus.no_l1a),     int'(e_miss));
        check({tag, ".orphan"},    int'(bus.l1a_orphan), int'(e_orphan));
        check({tag, ".ovlp"},      int'(bus.lct_ovlp),   int'(e_ovlp));
        check({tag, ".match_cnt"}, int'(bus.match_cnt),  e_match_cnt);
        check({tag, ".miss_cnt"},  int'(bus.miss_cnt),   e_miss_cnt);
    endtask

    // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
    task automatic cycle(input string tag, input bit ce, input bit lct, input bit l1a, input bit clr);
        bus.ce      = ce;
        bus.lct_dly = lct;
        bus.l1a     = l1a;
        bus.cnt_clr = clr;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N       = 1'b0;
        bus.ce      = 1'b0;
        bus.lct_dly = 1'b0;
        bus.l1a     = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.win     = 4'd3;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        idle("post_reset", 2);

        // WIN=3, L1A two edges after the LCT: match, window runs out.
        bus.win = 4'd3;
        cycle("t1_lct", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("t1_w1", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("t1_l1a", 1'b1, 1'b0, 1'b1, 1'b0);
        check("t1_match_pulse", int'(bus.l1a_match), 1);
        idle("t1_tail", 3);
        check("t1_busy_fallen", int'(bus.busy), 0);

        // WIN=3, no L1A: miss on the last window edge, back-to-back window.
        cycle("t2_lct", 1'b1, 1'b1, 1'b0, 1'b0);
        idle("t2_win", 2);
        cycle("t2_last", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_no_l1a_pulse", int'(bus.no_l1a), 1);
        cycle("t2_relct", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_reopen_busy", int'(bus.busy), 1);
        idle("t2_tail", 4);

        // WIN=0: immediate match, BUSY never rises, next L1A is an orphan.
        bus.win = 4'd0;
        cycle("t3_lct_l1a", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_busy_low", int'(bus.busy), 0);
        cycle("t3_orphan", 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("t3_miss", 1'b1, 1'b1, 1'b0, 1'b0);
        idle("t3_tail", 1);

        // WIN=4: match, overlapping LCT, second L1A orphan, fixed window length.
        bus.win = 4'd4;
        cycle("t4_lct", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("t4_l1a", 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("t4_ovlp", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("t4_orphan", 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("t4_last", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_busy_fallen", int'(bus.busy), 0);
        idle("t4_tail", 2);

        // Counter saturation, then clear colliding with a match.
        bus.win = 4'd0;
        for (int i = 0; i < 300; i++) cycle("t5_sat", 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef MATCH_CNT_EN
        check("t5_saturated", int'(bus.match_cnt), CNT_MAX);
`else
        check("t5_tied_zero", int'(bus.match_cnt), 0);
`endif
        cycle("t5_clr", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_cleared", int'(bus.match_cnt), 0);

        // Reset in the middle of a window: no NO_L1A, later L1A is an orphan.
        bus.win = 4'd7;
        cycle("t6_lct", 1'b1, 1'b1, 1'b0, 1'b0);
        idle("t6_win", 3);
        async_reset("t6_rst");
        idle("t6_after", 8);
        cycle("t6_orphan", 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_orphan_pulse", int'(bus.l1a_orphan), 1);

        // Randomized traffic, including CE gaps, clears, WIN changes and resets.
        for (int i = 0; i < 4000; i++) begin
            if (!m_open && $urandom_range(0, 7) == 0) bus.win = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 49) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
